// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the multi-cycle memory responder.
// Imported by the bus interface, storage array and responder FSM.
package mem_responder_pkg;

    localparam int WORD_W      = 16;
    localparam int LATENCY_DEF = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_responder_if.sv
// Fetch/data request bus between the multicycle controller and memory.
// master = controller side, slave = memory responder side.
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic              i_read;
    logic [WORD_W-1:0] i_addr;
    logic [WORD_W-1:0] i_data;
    logic              i_ready;
    logic              d_read;
    logic              d_write;
    logic [WORD_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic [WORD_W-1:0] d_rdata;
    logic              d_ready;
    logic              busy;
    logic              err;

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata,
        input  i_data, i_ready, d_rdata, d_ready, busy, err
    );

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata,
        output i_data, i_ready, d_rdata, d_ready, busy, err
    );

endinterface

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle responder: arbitrates fetch/data requests, one at a time,
// and pulses the winning port's ready LATENCY cycles after acceptance.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              port_q, port_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              accept;
    logic              resp;
    logic              we;
    logic [WORD_W-1:0] rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Data port has priority; a losing fetch simply stays held.
                if (bus.d_read || bus.d_write) begin
                    accept  = 1'b1;
                    port_d  = PORT_D;
                    wr_d    = bus.d_write;
                    err_d   = bus.d_read && bus.d_write;
                    addr_d  = bus.d_addr[AW-1:0];
                    wdata_d = bus.d_wdata;
                end else if (bus.i_read) begin
                    accept  = 1'b1;
                    port_d  = PORT_I;
                    wr_d    = 1'b0;
                    err_d   = 1'b0;
                    addr_d  = bus.i_addr[AW-1:0];
                end
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            port_q  <= PORT_I;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign resp = (state_q == ST_RESP);
    // A reset landing on the commit edge aborts the write.
    assign we   = resp && wr_q && !reset;

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .raddr_i (addr_q),
        .rdata_o (rdata)
    );

    assign bus.i_ready = resp && (port_q == PORT_I);
    assign bus.d_ready = resp && (port_q == PORT_D);
    assign bus.i_data  = bus.i_ready ? rdata : '0;
    assign bus.d_rdata = (bus.d_ready && !wr_q) ? rdata : '0;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.err     = resp && err_q;

endmodule
